cpu_timing_ctrl: RTL and testbench

Cycle sequencer for the 6502 core. It runs the T-state counter and generates the sync strobe that loads the instruction register on each opcode fetch. It stretches instructions for page-cross and taken-branch cycles and stalls on RDY. It also injects NMI/IRQ/RESET sequences at instruction boundaries. It sits between the opcode decode ROM (which supplies the base cycle count) and the IR/PC/address-mux datapath.

---
 rtl/cpu_timing_ctrl_if.sv | 28 ++
 rtl/cpu_timing_ctrl.sv | 136 +++++++++++++
 tb/tb_cpu_timing_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_timing_ctrl_if.sv
// Signal bundle between the 6502 cycle sequencer and the decode ROM / IR-PC datapath.
// The master side drives bus direction, ready, decode info and interrupt lines.
interface cpu_timing_ctrl_if;
  logic       rdy;
  logic       rw;
  logic [2:0] op_cycles;
  logic       extend;
  logic       irq_n;
  logic       nmi_n;
  logic       i_flag;

  logic       sync;
  logic [3:0] tstate;
  logic       pc_inc;
  logic       int_inject;
  logic [1:0] int_vec;
  logic       reset_seq;

  modport master (
    output rdy, rw, op_cycles, extend, irq_n, nmi_n, i_flag,
    input  sync, tstate, pc_inc, int_inject, int_vec, reset_seq
  );

  modport slave (
    input  rdy, rw, op_cycles, extend, irq_n, nmi_n, i_flag,
    output sync, tstate, pc_inc, int_inject, int_vec, reset_seq
  );
endinterface

// File: rtl/cpu_timing_ctrl.sv
// 6502 T-state sequencer: counts cycles per instruction, stretches for page-cross/branch,
// stalls on RDY for reads, and injects NMI/IRQ/RESET BRK sequences at instruction boundaries.
module cpu_timing_ctrl #(
  parameter int unsigned MAX_EXT  = 2,
  parameter int unsigned NMI_SYNC = 1
) (
  input  logic             clk,
  input  logic             rst,
  cpu_timing_ctrl_if.slave bus
);

  localparam int unsigned ExtW = (MAX_EXT > 0) ? $clog2(MAX_EXT + 1) : 1;
  localparam logic [ExtW-1:0] ExtMax = ExtW'(MAX_EXT);

  // Encoding doubles as the int_vec output.
  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StNmi   = 2'b01,
    StReset = 2'b10,
    StIrq   = 2'b11
  } seq_e;

  seq_e            seq_q, seq_d;
  logic [3:0]      tstate_q, tstate_d;
  logic [ExtW-1:0] ext_cnt_q, ext_cnt_d;
  logic            sync_q, sync_d;
  logic            pc_inc_q, pc_inc_d;
  logic            inject_q, inject_d;
  logic            nmi_pend_q, nmi_pend_d;
  logic            nmi_prev_q;

  logic            nmi_s;
  logic            nmi_fall;
  logic            enable;
  logic [2:0]      op_eff;
  logic [3:0]      last;
  logic            before_last;
  logic            at_last;
  logic            can_ext;
  logic            nmi_take;
  logic            irq_take;

  if (NMI_SYNC != 0) begin : g_nmi_sync
    logic [1:0] nmi_ff_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        nmi_ff_q <= 2'b11;
      end else begin
        nmi_ff_q <= {nmi_ff_q[0], bus.nmi_n};
      end
    end
    assign nmi_s = nmi_ff_q[1];
  end else begin : g_nmi_direct
    assign nmi_s = bus.nmi_n;
  end

  assign nmi_fall = nmi_prev_q & ~nmi_s;

  // Write cycles cannot be held off by RDY on the 6502 bus.
  assign enable      = bus.rdy | ~bus.rw;
  assign op_eff      = (bus.op_cycles < 3'd2) ? 3'd2 : bus.op_cycles;
  assign last        = 4'(op_eff) - 4'd1 + 4'(ext_cnt_q);
  assign before_last = tstate_q < last;
  assign at_last     = tstate_q == last;
  assign can_ext     = bus.extend & (ext_cnt_q < ExtMax);
  assign nmi_take    = nmi_pend_q | nmi_fall;
  assign irq_take    = ~bus.irq_n & ~bus.i_flag;

  always_comb begin
    seq_d      = seq_q;
    tstate_d   = tstate_q;
    ext_cnt_d  = ext_cnt_q;
    sync_d     = sync_q;
    pc_inc_d   = pc_inc_q;
    inject_d   = inject_q;
    // Edge capture keeps running through RDY stalls.
    nmi_pend_d = nmi_pend_q | nmi_fall;

    if (enable) begin
      sync_d   = 1'b0;
      pc_inc_d = 1'b0;
      inject_d = 1'b0;
      if (before_last) begin
        tstate_d = tstate_q + 4'd1;
      end else if (at_last && can_ext) begin
        tstate_d  = tstate_q + 4'd1;
        ext_cnt_d = ext_cnt_q + ExtW'(1);
      end else begin
        tstate_d  = 4'd0;
        ext_cnt_d = '0;
        sync_d    = 1'b1;
        if (nmi_take) begin
          inject_d   = 1'b1;
          seq_d      = StNmi;
          nmi_pend_d = 1'b0;
        end else if (irq_take) begin
          inject_d = 1'b1;
          seq_d    = StIrq;
        end else begin
          pc_inc_d = 1'b1;
          seq_d    = StRun;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q      <= StReset;
      tstate_q   <= 4'd1;
      ext_cnt_q  <= '0;
      sync_q     <= 1'b0;
      pc_inc_q   <= 1'b0;
      inject_q   <= 1'b0;
      nmi_pend_q <= 1'b0;
      nmi_prev_q <= 1'b1;
    end else begin
      seq_q      <= seq_d;
      tstate_q   <= tstate_d;
      ext_cnt_q  <= ext_cnt_d;
      sync_q     <= sync_d;
      pc_inc_q   <= pc_inc_d;
      inject_q   <= inject_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_prev_q <= nmi_s;
    end
  end

  assign bus.sync       = sync_q;
  assign bus.tstate     = tstate_q;
  assign bus.pc_inc     = pc_inc_q;
  assign bus.int_inject = inject_q;
  assign bus.int_vec    = seq_q;
  assign bus.reset_seq  = (seq_q == StReset);

endmodule

// File: tb/tb_cpu_timing_ctrl.sv
// Scenario bench for cpu_timing_ctrl: per-cycle expected outputs are queued as stimulus
// is applied and popped against the DUT just after each rising edge.
module tb_cpu_timing_ctrl;

  typedef struct packed {
    logic [3:0] t;
    logic       s;
    logic       pc;
    logic       inj;
    logic [1:0] v;
    logic       rs;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  cpu_timing_ctrl_if bus ();

  cpu_timing_ctrl #(
    .MAX_EXT  (2),
    .NMI_SYNC (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [3:0] t, input logic s, input logic pc,
                              input logic inj, input logic [1:0] v, input logic rs);
    obs_t o;
    o.t = t; o.s = s; o.pc = pc; o.inj = inj; o.v = v; o.rs = rs;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(bus.tstate, bus.sync, bus.pc_inc, bus.int_inject, bus.int_vec, bus.reset_seq);
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("t=%0d sync=%b pc_inc=%b inj=%b vec=%b reset_seq=%b",
                     o.t, o.s, o.pc, o.inj, o.v, o.rs);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    tick();
    exp_q.push_back(mk(4'd1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1));
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_hold got %s want %s", fmt(got), fmt(want));
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) exp_q.push_back(mk(4'(k + 2), 1'b0, 1'b0, 1'b0, 2'b10, 1'b1));
      else       exp_q.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0));
      tick();
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL reset_seq cyc%0d got %s want %s", k, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_extend();
    obs_t got, want;
    // extend held high: two extensions then forced boundary
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin bus.op_cycles = 3'd4; bus.extend = 1'b1; end
      if (k < 5) exp_q.push_back(mk(4'(k + 1), 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      else       exp_q.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0));
      tick();
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL extend_max cyc%0d got %s want %s", k, fmt(got), fmt(want));
      end
    end
    // extend only while tstate=1 must not lengthen the instruction
    for (int k = 0; k < 4; k++) begin
      bus.extend = (k == 1);
      if (k < 3) exp_q.push_back(mk(4'(k + 1), 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      else       exp_q.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0));
      tick();
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL extend_early cyc%0d got %s want %s", k, fmt(got), fmt(want));
      end
    end
    bus.extend = 1'b0;
  endtask

  task automatic test_min_cycles();
    obs_t got, want;
    for (int k = 0; k < 4; k++) begin
      bus.op_cycles = (k < 2) ? 3'd0 : 3'd1;
      if (k % 2 == 0) exp_q.push_back(mk(4'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      else            exp_q.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0));
      tick();
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL min_cycles cyc%0d got %s want %s", k, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_stall();
    obs_t got, want;
    // read stall at T1, then stall at T0 holding sync
    for (int k = 0; k < 7; k++) begin
      bus.op_cycles = 3'd3;
      bus.rw = 1'b1;
      bus.rdy = !((k >= 1 && k <= 3) || k == 6);
      if (k <= 3)      exp_q.push_back(mk(4'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      else if (k == 4) exp_q.push_back(mk(4'd2, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      else             exp_q.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0));
      tick();
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL stall_read cyc%0d got %s want %s", k, fmt(got), fmt(want));
      end
    end
    // write cycles ignore rdy
    for (int k = 0; k < 3; k++) begin
      bus.rdy = (k == 0);
      bus.rw  = (k == 0);
      if (k < 2) exp_q.push_back(mk(4'(k + 1), 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      else       exp_q.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0));
      tick();
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL stall_write cyc%0d got %s want %s", k, fmt(got), fmt(want));
      end
    end
    bus.rdy = 1'b1;
    bus.rw  = 1'b1;
  endtask

  task automatic test_irq();
    obs_t got, want;
    for (int k = 0; k < 11; k++) begin
      if (k == 0) begin bus.op_cycles = 3'd2; bus.irq_n = 1'b0; bus.i_flag = 1'b0; end
      if (k == 2) begin bus.op_cycles = 3'd7; bus.irq_n = 1'b1; end
      if (k == 9) begin bus.op_cycles = 3'd2; bus.irq_n = 1'b0; bus.i_flag = 1'b1; end
      if (k == 0)                exp_q.push_back(mk(4'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      else if (k == 1)           exp_q.push_back(mk(4'd0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0));
      else if (k >= 2 && k <= 7) exp_q.push_back(mk(4'(k - 1), 1'b0, 1'b0, 1'b0, 2'b11, 1'b0));
      else if (k == 9)           exp_q.push_back(mk(4'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      else                       exp_q.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0));
      tick();
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL irq cyc%0d got %s want %s", k, fmt(got), fmt(want));
      end
    end
    bus.irq_n = 1'b1;
  endtask

  task automatic test_nmi();
    obs_t got, want;
    for (int k = 0; k < 9; k++) begin
      if (k == 0) begin bus.op_cycles = 3'd5; bus.irq_n = 1'b0; bus.i_flag = 1'b0; end
      if (k == 1) bus.nmi_n = 1'b0;
      if (k == 2) bus.nmi_n = 1'b1;
      if (k == 5) bus.op_cycles = 3'd2;
      if (k == 7) bus.irq_n = 1'b1;
      if (k < 4)       exp_q.push_back(mk(4'(k + 1), 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      else if (k == 4) exp_q.push_back(mk(4'd0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0));
      else if (k == 5) exp_q.push_back(mk(4'd1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0));
      else if (k == 6) exp_q.push_back(mk(4'd0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0));
      else if (k == 7) exp_q.push_back(mk(4'd1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0));
      else             exp_q.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0));
      tick();
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL nmi cyc%0d got %s want %s", k, fmt(got), fmt(want));
      end
    end
    bus.i_flag = 1'b1;
  endtask

  task automatic test_nmi_boundary();
    obs_t got, want;
    // edge becomes visible in the same cycle that ends the instruction
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin bus.op_cycles = 3'd3; bus.nmi_n = 1'b0; end
      if (k == 1) bus.nmi_n = 1'b1;
      if (k == 3) bus.op_cycles = 3'd2;
      if (k < 2)       exp_q.push_back(mk(4'(k + 1), 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      else if (k == 2) exp_q.push_back(mk(4'd0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0));
      else if (k == 3) exp_q.push_back(mk(4'd1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0));
      else             exp_q.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0));
      tick();
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL nmi_edge_boundary cyc%0d got %s want %s", k, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, want;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin bus.op_cycles = 3'd5; bus.nmi_n = 1'b0; end
      if (k == 1) bus.nmi_n = 1'b1;
      exp_q.push_back(mk(4'(k + 1), 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      tick();
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL reset_mid_pre cyc%0d got %s want %s", k, fmt(got), fmt(want));
      end
    end
    #2;
    rst = 1'b1;
    exp_q.push_back(mk(4'd1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1));
    #1;
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_async got %s want %s", fmt(got), fmt(want));
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) exp_q.push_back(mk(4'(k + 2), 1'b0, 1'b0, 1'b0, 2'b10, 1'b1));
      else       exp_q.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0));
      tick();
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL reset_mid_post cyc%0d got %s want %s", k, fmt(got), fmt(want));
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.rdy       = 1'b1;
    bus.rw        = 1'b1;
    bus.op_cycles = 3'd5;
    bus.extend    = 1'b0;
    bus.irq_n     = 1'b1;
    bus.nmi_n     = 1'b1;
    bus.i_flag    = 1'b1;

    test_reset();
    test_extend();
    test_min_cycles();
    test_stall();
    test_irq();
    test_nmi();
    test_nmi_boundary();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
